// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    localparam int NO_IRQ_ID   = 0;
    localparam int DEF_NUM_IRQ = 8;
    localparam int DEF_ID_W    = 8;

    // Index width for a vector of n lines; a single line still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: reports the lowest set bit of vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N     = DEF_NUM_IRQ,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     vector,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vector[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end else begin
                valid = valid;
                index = index;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt sequencer: edge capture, pending/mask registers, fixed-priority
// selection and a request/acknowledge/return handshake toward the PC.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [NUM_IRQ-1:0] mask_out,
    output logic [NUM_IRQ-1:0] pending_out,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    input  logic               int_ack,
    input  logic               reti,
    output logic               in_service
);

    localparam int IDX_W = idx_width(NUM_IRQ);

    if (NUM_IRQ < 1 || NUM_IRQ > 255 || (2 ** ID_W) <= NUM_IRQ) begin : g_bad_params
        $error("irq_controller: need 1 <= NUM_IRQ <= 255 and 2**ID_W > NUM_IRQ");
    end

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               int_req_q, int_req_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic               in_service_q, in_service_d;

    logic [NUM_IRQ-1:0] edge_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] cand_s;
    logic               win_valid_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               ack_ok_s;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vector (cand_s),
        .valid  (win_valid_s),
        .index  (win_idx_s)
    );

    // Edge capture, ack-driven clear (a same-cycle edge wins) and mask load.
    always_comb begin
        ack_ok_s   = (state_q == IRQ_REQ) && int_ack;
        edge_s     = irq_in & ~irq_prev_q;
        irq_prev_d = irq_in;
        clr_s      = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_s[i] = ack_ok_s && (int_id_q == ID_W'(i + 1));
        end
        pending_d = (pending_q & ~clr_s) | edge_s;
        cand_s    = pending_q & mask_q;
        if (mask_wr) begin
            mask_d = mask_wdata;
        end else begin
            mask_d = mask_q;
        end
    end

    // Next-state and registered-output logic; the request id is frozen once committed.
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;
        case (state_q)
            IRQ_IDLE: begin
                if (win_valid_s) begin
                    state_d   = IRQ_REQ;
                    int_req_d = 1'b1;
                    int_id_d  = ID_W'(win_idx_s) + ID_W'(1);
                end else begin
                    int_req_d = 1'b0;
                end
            end
            IRQ_REQ: begin
                if (int_ack) begin
                    state_d      = IRQ_SERVICE;
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                end else begin
                    int_req_d = 1'b1;
                end
            end
            IRQ_SERVICE: begin
                if (reti) begin
                    state_d      = IRQ_IDLE;
                    in_service_d = 1'b0;
                    int_id_d     = ID_W'(NO_IRQ_ID);
                end else begin
                    in_service_d = 1'b1;
                end
            end
            default: begin
                state_d      = IRQ_IDLE;
                int_req_d    = 1'b0;
                int_id_d     = ID_W'(NO_IRQ_ID);
                in_service_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IRQ_IDLE;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            int_req_q    <= 1'b0;
            int_id_q     <= ID_W'(NO_IRQ_ID);
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign mask_out    = mask_q;
    assign pending_out = pending_q;
    assign int_req     = int_req_q;
    assign int_id      = int_id_q;
    assign in_service  = in_service_q;

endmodule
